// File: rtl/psec6_readout_pkg.sv
// rtl/psec6_readout_pkg.sv - shared state encoding and default sizes for the readout sequencer
package psec6_readout_pkg;

  localparam int DEF_NUM_CH    = 8;
  localparam int DEF_NUM_REG   = 5;
  localparam int DEF_WORD_BITS = 16;
  localparam int CH_W          = $clog2(DEF_NUM_CH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SEEK  = 3'd1,
    S_LOAD  = 3'd2,
    S_SHIFT = 3'd3,
    S_NEXT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/lowest_set_index.sv
// rtl/lowest_set_index.sv - priority encoder returning the index of the lowest set bit
module lowest_set_index #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] index,
  output logic         any
);

  // Scan from the top down so the lowest set bit is the last to write.
  always_comb begin
    index = '0;
    any   = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        index = W'(i);
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/readout_sequencer.sv
// rtl/readout_sequencer.sv - mask-driven scan of channel counter words onto the serial readout path
module readout_sequencer
  import psec6_readout_pkg::*;
#(
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter int NUM_REG   = DEF_NUM_REG,
  parameter int WORD_BITS = DEF_WORD_BITS
) (
  input  logic                       spi_clk,
  input  logic                       rstn,
  input  logic                       cs,
  input  logic                       inst_readout,
  input  logic [NUM_CH-1:0]          trigger_channel_mask,
  input  logic                       hold,
  output logic [$clog2(NUM_CH)-1:0]  ch_sel,
  output logic [$clog2(NUM_REG)-1:0] select_reg,
  output logic                       load_strobe,
  output logic                       shift_en,
  output logic                       busy,
  output logic                       done
);

  localparam int CW = $clog2(NUM_CH);
  localparam int RW = $clog2(NUM_REG);
  localparam int BW = $clog2(WORD_BITS);

  state_t          state;
  logic [NUM_CH-1:0] pending;
  logic [BW-1:0]   bit_cnt;
  logic            shift_active;
  logic [CW-1:0]   low_idx;
  logic            low_any;

  lowest_set_index #(.N(NUM_CH), .W(CW)) u_seek (
    .vec   (pending),
    .index (low_idx),
    .any   (low_any)
  );

  // Back-pressure must stall the very cycle it is raised, so only this output is combinational.
  assign shift_en = shift_active & ~hold;

  always_ff @(posedge spi_clk) begin
    if (!rstn) begin
      state        <= S_IDLE;
      ch_sel       <= '0;
      select_reg   <= '0;
      load_strobe  <= 1'b0;
      shift_active <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pending      <= '0;
      bit_cnt      <= '0;
    end else if (cs && state != S_IDLE) begin
      state        <= S_IDLE;
      load_strobe  <= 1'b0;
      shift_active <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pending      <= '0;
    end else begin
      load_strobe <= 1'b0;
      done        <= 1'b0;
      case (state)
        S_IDLE: begin
          if (inst_readout && !cs) begin
            state      <= S_SEEK;
            pending    <= trigger_channel_mask;
            select_reg <= '0;
            busy       <= 1'b1;
          end
        end
        S_SEEK: begin
          if (!low_any) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            state       <= S_LOAD;
            ch_sel      <= low_idx;
            select_reg  <= '0;
            load_strobe <= 1'b1;
          end
        end
        S_LOAD: begin
          state        <= S_SHIFT;
          bit_cnt      <= '0;
          shift_active <= 1'b1;
        end
        S_SHIFT: begin
          if (!hold) begin
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == BW'(WORD_BITS - 1)) begin
              state        <= S_NEXT;
              shift_active <= 1'b0;
            end
          end
        end
        S_NEXT: begin
          if (select_reg == RW'(NUM_REG - 1)) begin
            state           <= S_SEEK;
            pending[ch_sel] <= 1'b0;
          end else begin
            state       <= S_LOAD;
            select_reg  <= select_reg + 1'b1;
            load_strobe <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state        <= S_IDLE;
          busy         <= 1'b0;
          shift_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_readout_sequencer.sv
// tb/tb_readout_sequencer.sv - directed self-checking bench for readout_sequencer
module tb_readout_sequencer;

  logic       spi_clk = 1'b0;
  logic       rstn = 1'b0;
  logic       cs = 1'b0;
  logic       inst_readout = 1'b0;
  logic       hold = 1'b0;
  logic [7:0] mask = 8'h00;
  logic [2:0] ch_sel;
  logic [2:0] select_reg;
  logic       load_strobe;
  logic       shift_en;
  logic       busy;
  logic       done;

  readout_sequencer dut (
    .spi_clk              (spi_clk),
    .rstn                 (rstn),
    .cs                   (cs),
    .inst_readout         (inst_readout),
    .trigger_channel_mask (mask),
    .hold                 (hold),
    .ch_sel               (ch_sel),
    .select_reg           (select_reg),
    .load_strobe          (load_strobe),
    .shift_en             (shift_en),
    .busy                 (busy),
    .done                 (done)
  );

  always #5 spi_clk = ~spi_clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int         done_k;
  int         shifts;
  int         busy_n;
  int         first_word_shifts;
  logic [5:0] ld_q[$];
  int         ldk_q[$];
  logic       ab_busy, ab_load, ab_shift, ab_done;

  // k counts rising edges after the start pulse was presented; state "t+k" is sampled at step k.
  task automatic run(input logic [7:0] m, input int hold_start, input int abort_k,
                     input int extra_k, input int limit);
    done_k = -1; shifts = 0; busy_n = 0; first_word_shifts = 0;
    ld_q.delete(); ldk_q.delete();
    ab_busy = 1'bx; ab_load = 1'bx; ab_shift = 1'bx; ab_done = 1'bx;
    mask = m;
    inst_readout = 1'b1;
    for (int k = 1; k <= limit; k++) begin
      @(posedge spi_clk);
      #1;
      inst_readout = (k == extra_k);
      cs   = (k == abort_k);
      hold = (hold_start > 0 && k >= hold_start && k < hold_start + 3);
      if (k == 2) mask = ~m;
      #1;
      if (abort_k > 0 && k == abort_k + 1) begin
        ab_busy = busy; ab_load = load_strobe; ab_shift = shift_en; ab_done = done;
      end
      if (load_strobe) begin
        ld_q.push_back({ch_sel, select_reg});
        ldk_q.push_back(k);
      end
      if (shift_en) begin
        shifts++;
        if (ld_q.size() == 1) first_word_shifts++;
      end
      if (busy) busy_n++;
      if (done && done_k < 0) done_k = k;
      if (done_k > 0 && k >= done_k + 2) break;
    end
    cs = 1'b0; hold = 1'b0; inst_readout = 1'b0;
    @(posedge spi_clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge spi_clk);
    #1;
    check("rst_ch_sel", ch_sel, 0);
    check("rst_select_reg", select_reg, 0);
    check("rst_load", load_strobe, 0);
    check("rst_shift", shift_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rstn = 1'b1;
    @(posedge spi_clk);
    #1;

    // Full scan, with a stray start pulse mid-scan that must be ignored.
    run(8'hFF, 0, 0, 100, 800);
    check("full_done_k", done_k, 730);
    check("full_loads", ld_q.size(), 40);
    check("full_shifts", shifts, 640);
    check("full_busy_cycles", busy_n, 730);
    check("full_first_load_k", (ldk_q.size() > 0) ? ldk_q[0] : -1, 2);
    for (int i = 0; i < 40; i++)
      check($sformatf("full_addr_%0d", i), (i < ld_q.size()) ? ld_q[i] : 6'h3F,
            {3'(i / 5), 3'(i % 5)});

    run(8'h84, 0, 0, 0, 300);
    check("sparse_done_k", done_k, 184);
    check("sparse_loads", ld_q.size(), 10);
    check("sparse_shifts", shifts, 160);
    check("sparse_first", (ld_q.size() > 0) ? ld_q[0] : 6'h3F, {3'd2, 3'd0});
    check("sparse_sixth", (ld_q.size() > 5) ? ld_q[5] : 6'h3F, {3'd7, 3'd0});
    check("sparse_last", (ld_q.size() > 9) ? ld_q[9] : 6'h3F, {3'd7, 3'd4});

    run(8'h00, 0, 0, 0, 20);
    check("empty_done_k", done_k, 2);
    check("empty_loads", ld_q.size(), 0);
    check("empty_busy_cycles", busy_n, 2);

    run(8'h01, 7, 0, 0, 200);
    check("hold_done_k", done_k, 96);
    check("hold_shifts", shifts, 80);
    check("hold_first_word_shifts", first_word_shifts, 16);
    check("hold_second_load_k", (ldk_q.size() > 1) ? ldk_q[1] : -1, 23);

    // Abort during channel 3 register 2 (that LOAD lands at step 311).
    run(8'hFF, 0, 315, 50, 400);
    check("abort_no_done", done_k, -1);
    check("abort_busy", ab_busy, 0);
    check("abort_load", ab_load, 0);
    check("abort_shift", ab_shift, 0);
    check("abort_done_pulse", ab_done, 0);
    check("abort_loads", ld_q.size(), 18);
    check("abort_last_addr", (ld_q.size() > 17) ? ld_q[17] : 6'h3F, {3'd3, 3'd2});

    run(8'h01, 0, 0, 0, 200);
    check("restart_first_addr", (ld_q.size() > 0) ? ld_q[0] : 6'h3F, {3'd0, 3'd0});
    check("restart_first_load_k", (ldk_q.size() > 0) ? ldk_q[0] : -1, 2);
    check("restart_done_k", done_k, 93);

    // Reset mid-SHIFT of the first word.
    mask = 8'hFF;
    inst_readout = 1'b1;
    @(posedge spi_clk);
    #1;
    inst_readout = 1'b0;
    repeat (4) @(posedge spi_clk);
    #1;
    check("pre_reset_shift", shift_en, 1);
    rstn = 1'b0;
    @(posedge spi_clk);
    #1;
    rstn = 1'b1;
    check("mid_rst_ch_sel", ch_sel, 0);
    check("mid_rst_select_reg", select_reg, 0);
    check("mid_rst_load", load_strobe, 0);
    check("mid_rst_shift", shift_en, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    repeat (3) @(posedge spi_clk);
    #1;
    check("post_rst_idle_busy", busy, 0);
    check("post_rst_idle_load", load_strobe, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/readout_sequencer.md
# readout_sequencer

Sequences counter readout from the eight digital channels after a readout instruction. It walks every enabled channel and, within each channel, every counter register. For each word it drives the channel/register select, issues a load strobe and then a fixed-length shift window to the shared serial readout path. It sits between the SPI instruction pulse generator (`inst_readout`) and the channel digital blocks. It replaces the single static `select_reg` with an autonomous, mask-driven scan.

## Interface
Parameters:
- `NUM_CH`, 8: number of channels; `ch_sel` width is `$clog2(NUM_CH)`.
- `NUM_REG`, 5: counter registers per channel; `select_reg` carries 0..NUM_REG-1.
- `WORD_BITS`, 16: shift cycles per register word.

Ports:
- `spi_clk` in 1: the single clock; all state on its rising edge.
- `rstn` in 1: synchronous, active-low reset.
- `cs` in 1: high aborts any scan in progress (SPI transaction ended).
- `inst_readout` in 1: one-cycle start pulse.
- `trigger_channel_mask` in NUM_CH: channels to read; sampled only at start.
- `hold` in 1: downstream back-pressure; stalls the SHIFT state.
- `ch_sel` out 3: channel currently addressed.
- `select_reg` out 3: register currently addressed.
- `load_strobe` out 1: one-cycle parallel-load of addressed word.
- `shift_en` out 1: serial shift enable.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse on scan completion (not on abort).

## Operation
- States: IDLE, SEEK, LOAD, SHIFT, NEXT, DONE.
- IDLE to SEEK:
  - Taken when `inst_readout`=1 and `cs`=0.
  - `pending` <= `trigger_channel_mask`, `select_reg` <= 0.
  - `inst_readout` while `busy` is ignored.
- SEEK, with `pending`=0: go to DONE.
- SEEK, with `pending`≠0:
  - `ch_sel` <= index of lowest set bit of `pending` (priority encoder, single cycle).
  - `select_reg` <= 0.
  - Go to LOAD.
- LOAD: `load_strobe`=1 for exactly one cycle; bit counter <= 0; go to SHIFT.
- SHIFT:
  - `shift_en`=1 when `hold`=0, and the bit counter increments.
  - When `hold`=1, `shift_en`=0 and the counter holds.
  - Leave for NEXT on the cycle the counter reaches WORD_BITS-1 with `hold`=0.
- NEXT, when `select_reg` < NUM_REG-1: `select_reg`++ and go to LOAD.
- NEXT, when `select_reg` = NUM_REG-1: clear `pending[ch_sel]` and go to SEEK.
- DONE: `done`=1 for one cycle, then IDLE. `ch_sel` and `select_reg` hold their last values.
- Abort: `cs`=1 in any non-IDLE state goes to IDLE next cycle.
  - `load_strobe` and `shift_en` drop that cycle; `done` does not pulse.
  - `pending` is cleared.
- Reset has priority over abort and all transitions.

## Timing
- Reset values:
  - State IDLE.
  - `ch_sel`=0, `select_reg`=0.
  - `load_strobe`=0, `shift_en`=0, `busy`=0, `done`=0.
  - `pending`=0.
- All outputs are registered, except `shift_en`, which is gated combinationally by `hold`.
- Start latency: `inst_readout` at cycle t gives SEEK at t+1, and `load_strobe` at t+2 (first channel).
- Per word, with no hold: 1 LOAD + WORD_BITS SHIFT + 1 NEXT = 18 cycles.
- Per channel: NUM_REG×18 = 90 cycles, plus 1 SEEK.
- Full scan with all 8 channels: 1 + 8×91 + 1 (final SEEK) = 730 cycles from start to `done`.
- Empty mask: `done` at t+2.
- `ch_sel` and `select_reg` are stable from LOAD through NEXT of each word. They change only on the SEEK/NEXT edge.
- Mask changes during a scan have no effect.

## Structure
Shared package `psec6_readout_pkg` holds:
- the `state_t` enum;
- NUM_CH, NUM_REG, WORD_BITS defaults;
- the `CH_W` localparam.

Sub-module `lowest_set_index` (parameterized priority encoder, NUM_CH to CH_W, plus `any` flag) is instantiated once for SEEK. Everything else stays in the top module.

## Test plan
- Reset mid-SHIFT: `rstn`=0 for one cycle while SHIFT (mask 0xFF) → next cycle all outputs at reset values, and state is IDLE.
- Full scan: mask 0xFF, `inst_readout` pulse → 40 `load_strobe` pulses, `ch_sel` 0..7 each with `select_reg` 0..4, 640 `shift_en` cycles, `done` at start+730.
- Sparse mask: mask 0x84 → only `ch_sel` 2 then 7 visited, 10 loads, `done` at start+184.
- Empty mask: mask 0x00 → no `load_strobe`, `done` pulse at start+2, `busy` high for exactly 2 cycles.
- Hold stall: `hold`=1 for 3 cycles during the 5th shift bit of the first word → that word's SHIFT lasts 19 cycles, with no bit skipped or duplicated. Total `shift_en` count is unchanged.
- Abort: `cs`=1 during channel 3, register 2 → IDLE next cycle, no `done`. A new `inst_readout` then restarts from `ch_sel`=0 and `select_reg`=0. `inst_readout` pulses issued while `busy` are ignored.
